deserializer: RTL

Serial-to-parallel receiver, the counterpart of the team's MSB-first shift-out serializer. It samples one bit per qualified clock into a shift register and assembles words of REG_SIZE bits. Each completed word is presented on a parallel port under a valid/ready handshake, with a one-word holding register and a sticky overrun flag. It sits at the receive end of point-to-point serial links between tiles and debug/IO logic.

---
 rtl/deserializer_pkg.sv | 10 +
 rtl/valid_holding_reg.sv | 58 +++++
 rtl/deserializer.sv | 74 +++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// Shared types for the serial receive path.
// Holding-register occupancy states live here so sub-blocks agree on them.
package deserializer_pkg;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/valid_holding_reg.sv
// One-word output holding register with a valid/ready handshake.
// A word arriving while occupied and not drained is reported on drop.
import deserializer_pkg::*;

module valid_holding_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drop
);

    hold_state_t state;
    hold_state_t state_nxt;
    logic        load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HOLD_EMPTY;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) out_data <= in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        unique case (state)
            HOLD_EMPTY: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                // A new word replaces the old one only if the old one leaves now
                if (in_valid) begin
                    if (out_ready) load = 1'b1;
                    else           drop = 1'b1;
                end else if (out_ready) begin
                    state_nxt = HOLD_EMPTY;
                end
            end
            default: state_nxt = HOLD_EMPTY;
        endcase
    end

    assign out_valid = (state == HOLD_FULL);

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with a one-word holding register
// and a sticky overrun flag cleared by sync.
import deserializer_pkg::*;

module deserializer #(
    parameter int REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_in,
    input  logic                shift_en,
    input  logic                sync,
    output logic [REG_SIZE-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                frame_done,
    output logic                overrun
);

    localparam int CW = $clog2(REG_SIZE) + 1;

    logic [CW-1:0]       cnt;
    logic [REG_SIZE-2:0] shreg;
    logic [REG_SIZE-1:0] word;
    logic                last;
    logic                complete;
    logic                drop;

    // Only REG_SIZE-1 bits need storing; the final bit comes straight from data_in
    assign word     = {shreg, data_in};
    assign last     = (cnt == CW'(REG_SIZE - 1));
    assign complete = shift_en & ~sync & last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            shreg      <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= complete;
            if (sync) begin
                cnt     <= '0;
                shreg   <= '0;
                overrun <= 1'b0;
            end else begin
                if (shift_en) begin
                    if (last) begin
                        cnt   <= '0;
                        shreg <= '0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        shreg <= word[REG_SIZE-2:0];
                    end
                end
                if (drop) overrun <= 1'b1;
            end
        end
    end

    valid_holding_reg #(
        .WIDTH(REG_SIZE)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .in_valid (complete),
        .in_data  (word),
        .out_ready(data_ready),
        .out_valid(data_valid),
        .out_data (data_out),
        .drop     (drop)
    );

endmodule
